// File: rtl/hdlc_line_monitor.sv
// Passive HDLC serial-line monitor: flag/abort detection, zero destuffing,
// frame length classification and saturating event counters.
module hdlc_line_monitor #(
  parameter int MIN_FRAME_BYTES = 4,
  parameter int MAX_FRAME_BYTES = 128,
  parameter int LEN_W           = 8,
  parameter int CNT_W           = 16
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             en_i,
  input  logic             line_i,
  input  logic             clr_i,
  output logic             frame_active_o,
  output logic             flag_det_o,
  output logic             abort_det_o,
  output logic             frame_done_o,
  output logic [LEN_W-1:0] frame_bytes_o,
  output logic             err_short_o,
  output logic             err_long_o,
  output logic             err_nonoctet_o,
  output logic [CNT_W-1:0] cnt_frames_o,
  output logic [CNT_W-1:0] cnt_aborts_o,
  output logic [CNT_W-1:0] cnt_errors_o
);

  localparam int BIT_MAX = MAX_FRAME_BYTES * 8 + 8;
  localparam int BC_W    = $clog2(BIT_MAX + 1);

  // state   | meaning
  // HUNT    | idle line, waiting for a flag
  // OPEN    | flag seen, next bit starts a frame
  // FRAME   | collecting destuffed payload bits
  // DISCARD | over-long frame, ignore bits until a flag
  typedef enum logic [1:0] {HUNT, OPEN, FRAME, DISCARD} state_e;

  state_e            state_q, state_d;
  logic [7:0]        sr_q, sr_d;
  logic [2:0]        ones_q, ones_d;
  logic [BC_W-1:0]   bitcnt_q, bitcnt_d;
  logic              active_q, active_d;
  logic              flag_q, flag_d;
  logic              abort_q, abort_d;
  logic              done_q, done_d;
  logic [LEN_W-1:0]  bytes_q, bytes_d;
  logic              short_q, short_d;
  logic              long_q, long_d;
  logic              nonoct_q, nonoct_d;
  logic [CNT_W-1:0]  cnt_frames_q, cnt_frames_d;
  logic [CNT_W-1:0]  cnt_aborts_q, cnt_aborts_d;
  logic [CNT_W-1:0]  cnt_errors_q, cnt_errors_d;

  logic              flag_hit, abort_hit, stuffed;
  logic              inc_frames, inc_aborts, inc_errors;
  logic              err_nonoct, err_short;
  logic [BC_W-1:0]   payload, pbytes;

  function automatic logic [CNT_W-1:0] cnt_next(input logic [CNT_W-1:0] c,
                                                input logic inc,
                                                input logic clr);
    logic [CNT_W-1:0] r;
    r = c;
    if (clr)                r = '0;
    else if (inc && c != '1) r = c + CNT_W'(1);
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    sr_d       = sr_q;
    ones_d     = ones_q;
    bitcnt_d   = bitcnt_q;
    active_d   = active_q;
    bytes_d    = bytes_q;
    flag_d     = 1'b0;
    abort_d    = 1'b0;
    done_d     = 1'b0;
    short_d    = 1'b0;
    long_d     = 1'b0;
    nonoct_d   = 1'b0;
    inc_frames = 1'b0;
    inc_aborts = 1'b0;
    inc_errors = 1'b0;
    flag_hit   = 1'b0;
    abort_hit  = 1'b0;
    stuffed    = 1'b0;
    // The closing flag's leading 0 and six 1s were counted as payload bits.
    payload    = bitcnt_q - BC_W'(7);
    pbytes     = payload >> 3;
    err_nonoct = (payload[2:0] != 3'd0);
    err_short  = (pbytes < BC_W'(MIN_FRAME_BYTES));

    if (en_i) begin
      sr_d      = {sr_q[6:0], line_i};
      ones_d    = line_i ? ((ones_q == 3'd7) ? 3'd7 : ones_q + 3'd1) : 3'd0;
      flag_hit  = (sr_d == 8'h7E);
      abort_hit = line_i && (ones_q == 3'd6);
      stuffed   = !line_i && (ones_q == 3'd5);
      flag_d    = flag_hit;
      abort_d   = abort_hit;

      unique case (state_q)
        HUNT: begin
          if (flag_hit) begin
            state_d  = OPEN;
            bitcnt_d = '0;
          end
        end
        OPEN: begin
          if (abort_hit) begin
            state_d = HUNT;
          end else if (flag_hit) begin
            bitcnt_d = '0;
          end else begin
            state_d  = FRAME;
            active_d = 1'b1;
            bitcnt_d = BC_W'(1);
          end
        end
        FRAME: begin
          if (flag_hit) begin
            state_d  = OPEN;
            active_d = 1'b0;
            bitcnt_d = '0;
            // Fewer than 8 payload bits is inter-frame fill, not a frame.
            if (bitcnt_q >= BC_W'(15)) begin
              done_d   = 1'b1;
              bytes_d  = LEN_W'(pbytes);
              nonoct_d = err_nonoct;
              short_d  = err_short;
              if (err_nonoct || err_short) inc_errors = 1'b1;
              else                         inc_frames = 1'b1;
            end
          end else if (abort_hit) begin
            state_d    = HUNT;
            active_d   = 1'b0;
            inc_aborts = 1'b1;
          end else if (stuffed) begin
            bitcnt_d = bitcnt_q;
          end else if (bitcnt_q == BC_W'(BIT_MAX - 1)) begin
            state_d    = DISCARD;
            active_d   = 1'b0;
            bitcnt_d   = BC_W'(BIT_MAX);
            long_d     = 1'b1;
            inc_errors = 1'b1;
          end else begin
            bitcnt_d = bitcnt_q + BC_W'(1);
          end
        end
        DISCARD: begin
          if (flag_hit) begin
            state_d  = OPEN;
            bitcnt_d = '0;
          end else if (abort_hit) begin
            state_d = HUNT;
          end
        end
        default: state_d = HUNT;
      endcase
    end

    cnt_frames_d = cnt_next(cnt_frames_q, inc_frames, clr_i);
    cnt_aborts_d = cnt_next(cnt_aborts_q, inc_aborts, clr_i);
    cnt_errors_d = cnt_next(cnt_errors_q, inc_errors, clr_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= HUNT;
      sr_q         <= 8'hFF;
      ones_q       <= 3'd0;
      bitcnt_q     <= '0;
      active_q     <= 1'b0;
      flag_q       <= 1'b0;
      abort_q      <= 1'b0;
      done_q       <= 1'b0;
      bytes_q      <= '0;
      short_q      <= 1'b0;
      long_q       <= 1'b0;
      nonoct_q     <= 1'b0;
      cnt_frames_q <= '0;
      cnt_aborts_q <= '0;
      cnt_errors_q <= '0;
    end else begin
      state_q      <= state_d;
      sr_q         <= sr_d;
      ones_q       <= ones_d;
      bitcnt_q     <= bitcnt_d;
      active_q     <= active_d;
      flag_q       <= flag_d;
      abort_q      <= abort_d;
      done_q       <= done_d;
      bytes_q      <= bytes_d;
      short_q      <= short_d;
      long_q       <= long_d;
      nonoct_q     <= nonoct_d;
      cnt_frames_q <= cnt_frames_d;
      cnt_aborts_q <= cnt_aborts_d;
      cnt_errors_q <= cnt_errors_d;
    end
  end

  assign frame_active_o = active_q;
  assign flag_det_o     = flag_q;
  assign abort_det_o    = abort_q;
  assign frame_done_o   = done_q;
  assign frame_bytes_o  = bytes_q;
  assign err_short_o    = short_q;
  assign err_long_o     = long_q;
  assign err_nonoctet_o = nonoct_q;
  assign cnt_frames_o   = cnt_frames_q;
  assign cnt_aborts_o   = cnt_aborts_q;
  assign cnt_errors_o   = cnt_errors_q;

endmodule

// File: tb/tb_hdlc_line_monitor.sv
// Directed bench for hdlc_line_monitor: default instance plus a MAX_FRAME_BYTES=8
// instance sharing the same line, for the over-length case.
module tb_hdlc_line_monitor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic line = 1'b1;
  logic clr = 1'b0;

  logic        fa, fd, ad, dn, es, el, eno;
  logic [7:0]  fb;
  logic [15:0] cf, ca, ce;
  logic        fa8, fd8, ad8, dn8, es8, el8, eno8;
  logic [7:0]  fb8;
  logic [15:0] cf8, ca8, ce8;

  int n_checks = 0;
  int n_fail   = 0;
  int tx_ones  = 0;
  int n_flag = 0, n_abort = 0, n_done = 0, n_done8 = 0, n_long8 = 0;

  always #5 clk = ~clk;

  hdlc_line_monitor dut (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .line_i(line), .clr_i(clr),
    .frame_active_o(fa), .flag_det_o(fd), .abort_det_o(ad), .frame_done_o(dn),
    .frame_bytes_o(fb), .err_short_o(es), .err_long_o(el), .err_nonoctet_o(eno),
    .cnt_frames_o(cf), .cnt_aborts_o(ca), .cnt_errors_o(ce)
  );

  hdlc_line_monitor #(.MAX_FRAME_BYTES(8)) dut8 (
    .clk_i(clk), .rst_n_i(rst_n), .en_i(en), .line_i(line), .clr_i(clr),
    .frame_active_o(fa8), .flag_det_o(fd8), .abort_det_o(ad8), .frame_done_o(dn8),
    .frame_bytes_o(fb8), .err_short_o(es8), .err_long_o(el8), .err_nonoctet_o(eno8),
    .cnt_frames_o(cf8), .cnt_aborts_o(ca8), .cnt_errors_o(ce8)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (fd)  n_flag++;
      if (ad)  n_abort++;
      if (dn)  n_done++;
      if (dn8) n_done8++;
      if (el8) n_long8++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic send_bit(input logic b);
    @(negedge clk);
    en = 1'b1;
    line = b;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic send_data_bit(input logic b);
    send_bit(b);
    if (b) begin
      tx_ones++;
      if (tx_ones == 5) begin
        send_bit(1'b0);
        tx_ones = 0;
      end
    end else begin
      tx_ones = 0;
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    for (int i = 0; i < 8; i++) send_data_bit(v[i]);
  endtask

  task automatic send_flag();
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    send_bit(1'b0);
    tx_ones = 0;
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int bf, ba, bd, bd8, bl8;
    logic [7:0] b;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_active", 32'(fa), 0);
    check("rst_flag", 32'(fd), 0);
    check("rst_bytes", 32'(fb), 0);
    check("rst_cnt_frames", 32'(cf), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // 1: idle ones, then a 4-byte frame
    repeat (20) send_bit(1'b1);
    settle();
    bf = n_flag;
    send_flag();
    check("t1_open_flag", 32'(fd), 1);
    check("t1_open_active", 32'(fa), 0);
    b = 8'h12;
    for (int i = 0; i < 8; i++) begin
      send_data_bit(b[i]);
      if (i == 0) check("t1_active_first_bit", 32'(fa), 1);
    end
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    check("t1_active_mid", 32'(fa), 1);
    check("t1_no_early_done", 32'(dn), 0);
    send_flag();
    check("t1_done", 32'(dn), 1);
    check("t1_bytes", 32'(fb), 4);
    check("t1_short", 32'(es), 0);
    check("t1_nonoct", 32'(eno), 0);
    check("t1_cnt_frames", 32'(cf), 1);
    check("t1_active_after", 32'(fa), 0);
    settle();
    check("t1_flag_count", 32'(n_flag - bf), 2);
    check("t1_done_held", 32'(fb), 4);

    // 2: all-ones payload forces stuffed zeros
    repeat (5) send_byte(8'hFF);
    send_flag();
    check("t2_done", 32'(dn), 1);
    check("t2_bytes", 32'(fb), 5);
    check("t2_nonoct", 32'(eno), 0);
    check("t2_cnt_frames", 32'(cf), 2);

    // 3: fill flag, short frame, non-octet frame
    settle();
    bd = n_done;
    send_flag();
    settle();
    check("t3_fill_no_done", 32'(n_done - bd), 0);
    send_byte(8'hA5);
    send_byte(8'h3C);
    send_flag();
    check("t3_short_done", 32'(dn), 1);
    check("t3_short", 32'(es), 1);
    check("t3_short_bytes", 32'(fb), 2);
    check("t3_cnt_errors", 32'(ce), 1);
    check("t3_cnt_frames", 32'(cf), 2);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_data_bit(1'b1);
    send_data_bit(1'b0);
    send_data_bit(1'b1);
    send_flag();
    check("t3_nonoct", 32'(eno), 1);
    check("t3_nonoct_bytes", 32'(fb), 3);
    check("t3_nonoct_short", 32'(es), 1);
    check("t3_cnt_errors2", 32'(ce), 2);

    // 4: abort mid-frame
    send_flag();
    for (int i = 1; i <= 10; i++) send_byte(8'(i));
    settle();
    bd = n_done;
    ba = n_abort;
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    check("t4_no_abort_at_6", 32'(ad), 0);
    send_bit(1'b1);
    check("t4_abort", 32'(ad), 1);
    check("t4_cnt_aborts", 32'(ca), 1);
    check("t4_active", 32'(fa), 0);
    send_bit(1'b1);
    check("t4_abort_once", 32'(ad), 0);
    repeat (5) send_bit(1'b1);
    settle();
    check("t4_abort_count", 32'(n_abort - ba), 1);
    check("t4_no_done", 32'(n_done - bd), 0);

    // 5: over-length frame on the MAX_FRAME_BYTES=8 instance
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tx_ones = 0;
    settle();
    bd8 = n_done8;
    bl8 = n_long8;
    send_flag();
    for (int i = 1; i <= 8; i++) send_byte(8'(i));
    check("t5_no_long_at_8", 32'(el8), 0);
    send_byte(8'h09);
    check("t5_long", 32'(el8), 1);
    check("t5_cnt_errors8", 32'(ce8), 1);
    check("t5_active8", 32'(fa8), 0);
    send_flag();
    check("t5_no_done_at_flag", 32'(dn8), 0);
    settle();
    check("t5_done_count8", 32'(n_done8 - bd8), 0);
    check("t5_long_count8", 32'(n_long8 - bl8), 1);
    send_byte(8'h12);
    send_byte(8'h34);
    send_byte(8'h56);
    send_byte(8'h78);
    send_flag();
    check("t5_next_done8", 32'(dn8), 1);
    check("t5_next_bytes8", 32'(fb8), 4);
    check("t5_cnt_frames8", 32'(cf8), 1);
    check("t5_main_frames", 32'(cf), 2);

    // 6a: asynchronous reset mid-frame
    send_byte(8'h21);
    send_byte(8'h43);
    check("t6_active_before_rst", 32'(fa), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t6_rst_active", 32'(fa), 0);
    check("t6_rst_bytes", 32'(fb), 0);
    check("t6_rst_cnt_frames", 32'(cf), 0);
    check("t6_rst_bytes8", 32'(fb8), 0);
    check("t6_rst_cnt_errors8", 32'(ce8), 0);
    check("t6_rst_cnt_frames8", 32'(cf8), 0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_ones = 0;
    settle();
    bd = n_done;
    bf = n_flag;
    send_byte(8'h55);
    send_byte(8'hAA);
    send_flag();
    check("t6_resync_no_done", 32'(dn), 0);
    repeat (3) begin
      repeat (6) send_bit(1'b1);
      send_bit(1'b0);
    end
    settle();
    check("t6_shared_flags", 32'(n_flag - bf), 4);
    check("t6_shared_no_done", 32'(n_done - bd), 0);

    // 6b: clear coinciding with a frame-count increment
    send_byte(8'h01);
    send_byte(8'h02);
    send_byte(8'h03);
    send_byte(8'h04);
    send_flag();
    check("t6_frames_before_clr", 32'(cf), 1);
    send_byte(8'h05);
    send_byte(8'h06);
    send_byte(8'h07);
    send_byte(8'h08);
    send_bit(1'b0);
    repeat (6) send_bit(1'b1);
    clr = 1'b1;
    send_bit(1'b0);
    clr = 1'b0;
    check("t6_clr_done", 32'(dn), 1);
    check("t6_clr_frames", 32'(cf), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
